// File: rtl/vfd_bcd_scan.sv
// Three-grid VFD scanner: packed BCD in, serial grid+segment words out.
// Each digit is loaded, shifted MSB first, latched, then held for DWELL clocks.
module vfd_bcd_scan #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DWELL   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] bcd_in,
  output logic        vfd_sclk,
  output logic        vfd_sdata,
  output logic        vfd_lat,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned CNT_MAX = (2 * CLK_DIV > DWELL) ? 2 * CLK_DIV : DWELL;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] HOLD_PEN  = CNT_W'((DWELL > 1) ? DWELL - 2 : 0);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_HOLD} state_t;
  typedef enum logic [1:0] {D_HUND, D_TENS, D_ONES} digit_t;

  state_t            state_q;
  digit_t            digit_q;
  logic [11:0]       snap_q;
  logic [15:0]       shreg_q;
  logic [DIV_W-1:0]  div_q;
  logic [4:0]        half_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sclk_q, sdata_q, lat_q, busy_q, frame_done_q;

  logic [3:0]  nib;
  logic        blank;
  logic [2:0]  grid;
  logic [7:0]  seg;
  logic [15:0] word_d;

  always_comb begin
    nib   = snap_q[3:0];
    blank = 1'b0;
    grid  = 3'b001;
    case (digit_q)
      D_HUND: begin
        nib   = snap_q[11:8];
        blank = (snap_q[11:8] == 4'd0);
        grid  = 3'b100;
      end
      D_TENS: begin
        nib   = snap_q[7:4];
        blank = (snap_q[11:8] == 4'd0) && (snap_q[7:4] == 4'd0);
        grid  = 3'b010;
      end
      default: ;
    endcase
    case (nib)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = 8'h40;
    endcase
    if (blank) seg = '0;
    word_d = {5'b0, grid, seg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      digit_q      <= D_HUND;
      snap_q       <= '0;
      shreg_q      <= '0;
      div_q        <= '0;
      half_q       <= '0;
      cnt_q        <= '0;
      sclk_q       <= 1'b0;
      sdata_q      <= 1'b0;
      lat_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en) begin
            snap_q  <= bcd_in;
            digit_q <= D_HUND;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          shreg_q <= word_d;
          sdata_q <= word_d[15];
          sclk_q  <= 1'b0;
          div_q   <= '0;
          half_q  <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (half_q == 5'd31) begin
              sclk_q  <= 1'b0;
              lat_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_LATCH;
            end else begin
              half_q <= half_q + 5'd1;
              // Even half = low phase; the next bit is presented as the low phase begins.
              if (!half_q[0]) begin
                sclk_q <= 1'b1;
              end else begin
                sclk_q  <= 1'b0;
                sdata_q <= shreg_q[14];
                shreg_q <= {shreg_q[14:0], 1'b0};
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_LATCH: begin
          if (cnt_q == LAT_LAST) begin
            lat_q        <= 1'b0;
            sdata_q      <= 1'b0;
            cnt_q        <= '0;
            frame_done_q <= (digit_q == D_ONES) && (DWELL == 1);
            state_q      <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            if (digit_q != D_ONES) begin
              digit_q <= (digit_q == D_HUND) ? D_TENS : D_ONES;
              state_q <= S_LOAD;
            end else if (en) begin
              snap_q  <= bcd_in;
              digit_q <= D_HUND;
              state_q <= S_LOAD;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q        <= cnt_q + CNT_W'(1);
            frame_done_q <= (digit_q == D_ONES) && (cnt_q == HOLD_PEN);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vfd_sclk   = sclk_q;
  assign vfd_sdata  = sdata_q;
  assign vfd_lat    = lat_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vfd_bcd_scan.sv
// Bench for vfd_bcd_scan: decodes the serial link back into words and checks
// them against a digit-level display model, plus timing and corner sequences.
module tb_vfd_bcd_scan;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned DWELL   = 8;
  localparam int          FRAME   = 3 * (1 + 34 * CLK_DIV + DWELL);

  logic        clk = 1'b0;
  logic        rst, en;
  logic [11:0] bcd_in;
  logic        vfd_sclk, vfd_sdata, vfd_lat, busy, frame_done;

  vfd_bcd_scan #(.CLK_DIV(CLK_DIV), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in),
    .vfd_sclk(vfd_sclk), .vfd_sdata(vfd_sdata), .vfd_lat(vfd_lat),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Serial receiver: bits captured on sclk rising edges, 16 per word.
  logic [15:0] words[$];
  logic [15:0] cap_sr = '0;
  int          cap_n  = 0;
  always @(posedge vfd_sclk or posedge rst) begin
    if (rst) cap_n = 0;
    else begin
      cap_sr = {cap_sr[14:0], vfd_sdata};
      cap_n++;
      if (cap_n == 16) begin
        words.push_back(cap_sr);
        cap_n = 0;
      end
    end
  end

  // Link protocol watchers.
  int   lat_run = 0;
  int   lat_cnt = 0;
  logic prev_sd = 1'b0;
  logic prev_fd = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      lat_run = 0; prev_sd = 1'b0; prev_fd = 1'b0;
    end else begin
      if (vfd_sdata !== prev_sd) begin
        checks++;
        if (vfd_sclk !== 1'b0) begin
          errors++;
          $display("FAIL sdata_edge: sdata changed with sclk %b", vfd_sclk);
        end
      end
      prev_sd = vfd_sdata;
      if (vfd_lat) begin
        if (lat_run == 0) chk("lat_word_complete", cap_n, 0);
        lat_run++;
        if (vfd_sclk) chk("sclk_low_in_latch", vfd_sclk, 0);
      end else if (lat_run != 0) begin
        chk("lat_width", lat_run, 2 * CLK_DIV);
        lat_run = 0;
        lat_cnt++;
      end
      if (frame_done && prev_fd) chk("frame_done_one_clk", 2, 1);
      prev_fd = frame_done;
    end
  end

  // Display model: digits left of the first nonzero (or dash) nibble are dark.
  function automatic logic [15:0] model_word(input logic [11:0] v, input int d);
    logic [7:0] tab [10];
    int dig [3];
    int first;
    logic [7:0] s;
    tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    dig[0] = int'(v[11:8]);
    dig[1] = int'(v[7:4]);
    dig[2] = int'(v[3:0]);
    first = (dig[0] != 0) ? 0 : (dig[1] != 0) ? 1 : 2;
    if (d < first)       s = 8'h00;
    else if (dig[d] > 9) s = 8'h40;
    else                 s = tab[dig[d]];
    return {5'b0, 3'(4 >> d), s};
  endfunction

  task automatic wait_fd(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    chk(name, seen, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2 * FRAME && busy; i++) @(negedge clk);
    chk(name, busy, 0);
  endtask

  task automatic run_single(input logic [11:0] v);
    words.delete();
    bcd_in = v;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_fd("single_frame_done");
    @(negedge clk);
    chk("busy_after_frame", busy, 0);
  endtask

  task automatic chk_words(input string name, input logic [11:0] v, input int n);
    chk({name, "_count"}, words.size(), n);
    for (int k = 0; k < n && k < words.size(); k++)
      chk(name, words[k], model_word(v, k % 3));
  endtask

  typedef struct packed {
    logic [11:0] bcd;
    logic [15:0] w0, w1, w2;
  } vec_t;
  vec_t tbl [7];

  initial begin
    logic [11:0] v;
    int t0, lb;
    logic ok;

    tbl[0] = '{12'h205, 16'h045B, 16'h023F, 16'h016D};
    tbl[1] = '{12'h007, 16'h0400, 16'h0200, 16'h0107};
    tbl[2] = '{12'h0A0, 16'h0400, 16'h0240, 16'h013F};
    tbl[3] = '{12'h123, 16'h0406, 16'h025B, 16'h014F};
    tbl[4] = '{12'h999, 16'h046F, 16'h026F, 16'h016F};
    tbl[5] = '{12'h000, 16'h0400, 16'h0200, 16'h013F};
    tbl[6] = '{12'hF00, 16'h0440, 16'h023F, 16'h013F};

    rst = 1'b1; en = 1'b0; bcd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {vfd_sclk, vfd_sdata, vfd_lat, busy, frame_done}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    foreach (tbl[i]) begin
      run_single(tbl[i].bcd);
      chk("tbl_count", words.size(), 3);
      if (words.size() == 3) begin
        chk("tbl_w0", words[0], tbl[i].w0);
        chk("tbl_w1", words[1], tbl[i].w1);
        chk("tbl_w2", words[2], tbl[i].w2);
      end
    end

    for (int i = 0; i < 16; i++) begin
      v = 12'($urandom_range(0, 4095));
      if (i % 3 == 0) v = v & 12'h0FF;
      if (i % 5 == 0) v = v & 12'h00F;
      run_single(v);
      chk_words("rand_word", v, 3);
    end

    // Continuous scan: frame period and back-to-back frames.
    words.delete();
    bcd_in = 12'h205;
    en = 1'b1;
    wait_fd("cont_fd1");
    t0 = cyc;
    @(negedge clk);
    wait_fd("cont_fd2");
    chk("frame_period", cyc - t0, FRAME);
    @(negedge clk);
    en = 1'b0;
    wait_fd("cont_fd3");
    @(negedge clk);
    chk("cont_busy_low", busy, 0);
    chk_words("cont_word", 12'h205, 9);

    // bcd_in changes during the tens shift; snapshot holds until the next frame.
    words.delete();
    bcd_in = 12'h123;
    en = 1'b1;
    lb = lat_cnt;
    for (int i = 0; i < FRAME && lat_cnt != lb + 1; i++) @(negedge clk);
    chk("mid_hund_latched", lat_cnt, lb + 1);
    for (int i = 0; i < FRAME && !vfd_sclk; i++) @(negedge clk);
    chk("mid_tens_shifting", vfd_sclk, 1);
    bcd_in = 12'h999;
    wait_fd("mid_fd1");
    @(negedge clk);
    en = 1'b0;
    wait_fd("mid_fd2");
    @(negedge clk);
    chk("mid_count", words.size(), 6);
    if (words.size() == 6) begin
      for (int k = 0; k < 3; k++) chk("mid_frame1", words[k], tbl[3].w0 >> 0 == 0 ? 0 : model_word(12'h123, k));
      for (int k = 3; k < 6; k++) chk("mid_frame2", words[k], model_word(12'h999, k - 3));
    end

    // Reset mid-shift: outputs clear at once, no latch, restart from hundreds.
    words.delete();
    bcd_in = 12'h456;
    en = 1'b1;
    for (int i = 0; i < FRAME && cap_n != 7; i++) @(negedge clk);
    chk("rst_at_bit7", cap_n, 7);
    lb = lat_cnt;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {vfd_sclk, vfd_sdata, vfd_lat, busy, frame_done}, 0);
    repeat (3) @(negedge clk);
    chk("rst_held_outputs", {vfd_sclk, vfd_sdata, vfd_lat, busy, frame_done}, 0);
    chk("rst_no_latch", lat_cnt, lb);
    chk("rst_no_word", words.size(), 0);
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < FRAME && !ok; i++) begin
      @(negedge clk);
      ok = (words.size() != 0);
    end
    chk("rst_restart_seen", ok, 1);
    if (ok) chk("rst_restart_word", words[0], 16'h0466);
    en = 1'b0;
    wait_idle("rst_back_idle");

    // en dropped during the tens hold: frame still completes, then idle.
    words.delete();
    bcd_in = 12'h321;
    en = 1'b1;
    lb = lat_cnt;
    for (int i = 0; i < FRAME && lat_cnt != lb + 2; i++) @(negedge clk);
    chk("endrop_tens_latched", lat_cnt, lb + 2);
    en = 1'b0;
    wait_fd("endrop_fd");
    chk("endrop_busy_at_fd", busy, 1);
    @(negedge clk);
    chk("endrop_busy_fall", busy, 0);
    repeat (40) @(negedge clk);
    chk("endrop_quiet", {vfd_sclk, vfd_sdata, vfd_lat, busy, frame_done}, 0);
    chk_words("endrop_word", 12'h321, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
